// File: rtl/ball_ctrl_pkg.sv
// Shared state encoding and default playfield/platform geometry for the ball sequencer.
package ball_ctrl_pkg;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;
    localparam int unsigned PLAT_Y_DEF   = 110;
    localparam int unsigned PLAT_W_DEF   = 20;

    typedef enum logic [3:0] {
        ST_SERVE,
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_BRICK,
        ST_MOVE,
        ST_SETTLE,
        ST_LOST,
        ST_OVER
    } state_t;

endpackage

// File: rtl/ball_collide.sv
// Combinational wall/platform/floor decode for one step, using 11-bit unsigned arithmetic.
module ball_collide
    import ball_ctrl_pkg::*;
#(
    parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
    parameter int unsigned BALL_SIZE = 2,
    parameter int unsigned PLAT_Y    = PLAT_Y_DEF,
    parameter int unsigned PLAT_W    = PLAT_W_DEF
) (
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] platx,
    input  logic       x_du,
    input  logic       y_du,
    output logic       new_x_du,
    output logic       new_y_du,
    output logic       plat_hit,
    output logic       floor_hit
);

    logic [10:0] bx, by, px, bx_end, by_end;
    logic        top_hit;

    assign bx     = {1'b0, ball_x};
    assign by     = {1'b0, ball_y};
    assign px     = {1'b0, platx};
    assign bx_end = bx + 11'(BALL_SIZE);
    assign by_end = by + 11'(BALL_SIZE);

    always_comb begin
        new_x_du  = x_du;
        new_y_du  = y_du;
        top_hit   = (!y_du) && (by == '0);
        plat_hit  = y_du && (by_end == 11'(PLAT_Y)) &&
                    (bx_end > px) && (bx < px + 11'(PLAT_W));
        floor_hit = y_du && (by_end >= 11'(SCREEN_H));

        if (x_du && (bx_end >= 11'(SCREEN_W)))
            new_x_du = 1'b0;
        else if (!x_du && (bx == '0))
            new_x_du = 1'b1;

        if (top_hit)
            new_y_du = 1'b1;
        else if (plat_hit)
            new_y_du = 1'b0;
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball step sequencer: serve/launch, per-tick stepping, collision resolution, brick lookup, lives.
module ball_ctrl
    import ball_ctrl_pkg::*;
#(
    parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
    parameter int unsigned BALL_SIZE = 2,
    parameter int unsigned PLAT_Y    = PLAT_Y_DEF,
    parameter int unsigned PLAT_W    = PLAT_W_DEF,
    parameter int unsigned STEPS     = 1,
    parameter int unsigned LIVES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] platx,
    input  logic       brick_ack,
    input  logic       brick_hit,
    output logic       move_en,
    output logic       x_du,
    output logic       y_du,
    output logic       pos_resetn,
    output logic       brick_req,
    output logic [9:0] brick_qx,
    output logic [9:0] brick_qy,
    output logic       brick_clr,
    output logic       plat_col,
    output logic [1:0] lives,
    output logic       game_over
);

    state_t     state, next_state;
    logic [2:0] step_cnt;
    logic       tick_pend;
    logic       new_x_du, new_y_du, plat_hit, floor_hit;
    logic       stepping;

    ball_collide #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .BALL_SIZE (BALL_SIZE),
        .PLAT_Y    (PLAT_Y),
        .PLAT_W    (PLAT_W)
    ) u_collide (
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .platx     (platx),
        .x_du      (x_du),
        .y_du      (y_du),
        .new_x_du  (new_x_du),
        .new_y_du  (new_y_du),
        .plat_hit  (plat_hit),
        .floor_hit (floor_hit)
    );

    assign stepping = (state == ST_CHECK) || (state == ST_BRICK) ||
                      (state == ST_MOVE)  || (state == ST_SETTLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SERVE;
            x_du      <= 1'b1;
            y_du      <= 1'b0;
            step_cnt  <= '0;
            tick_pend <= 1'b0;
            lives     <= 2'(LIVES);
            brick_qx  <= '0;
            brick_qy  <= '0;
        end else begin
            state <= next_state;

            if (state == ST_WAIT)
                tick_pend <= 1'b0;
            else if (frame_tick && stepping)
                tick_pend <= 1'b1;

            case (state)
                ST_SERVE: begin
                    x_du <= 1'b1;
                    y_du <= 1'b0;
                end
                ST_WAIT: begin
                    if (frame_tick || tick_pend)
                        step_cnt <= 3'(STEPS);
                end
                ST_CHECK: begin
                    if (!floor_hit) begin
                        x_du     <= new_x_du;
                        y_du     <= new_y_du;
                        brick_qx <= new_x_du ? ball_x + 10'd1 : ball_x - 10'd1;
                        brick_qy <= new_y_du ? ball_y + 10'd1 : ball_y - 10'd1;
                    end
                end
                ST_BRICK: begin
                    if (brick_ack && brick_hit)
                        y_du <= ~y_du;
                end
                ST_MOVE:  step_cnt <= step_cnt - 3'd1;
                ST_LOST:  lives    <= lives - 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        move_en    = 1'b0;
        brick_req  = 1'b0;
        brick_clr  = 1'b0;
        plat_col   = 1'b0;
        pos_resetn = 1'b1;
        game_over  = 1'b0;

        case (state)
            ST_SERVE: begin
                pos_resetn = 1'b0;
                next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (launch)
                    next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_tick || tick_pend)
                    next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (floor_hit)
                    next_state = ST_LOST;
                else if (new_y_du != y_du) begin
                    plat_col   = plat_hit;
                    next_state = ST_MOVE;
                end else
                    next_state = ST_BRICK;
            end
            ST_BRICK: begin
                brick_req = 1'b1;
                if (brick_ack) begin
                    brick_clr  = brick_hit;
                    next_state = ST_MOVE;
                end
            end
            ST_MOVE: begin
                move_en    = 1'b1;
                next_state = (step_cnt <= 3'd1) ? ST_WAIT : ST_SETTLE;
            end
            // ball_pos only reflects move_en one edge later, so re-check after a spare cycle
            ST_SETTLE: next_state = ST_CHECK;
            ST_LOST: begin
                next_state = (lives <= 2'd1) ? ST_OVER : ST_SERVE;
            end
            ST_OVER: game_over = 1'b1;
            default: next_state = ST_SERVE;
        endcase
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: table of per-tick step vectors plus stall/reset sequences.
module tb_ball_ctrl;

    logic       clk = 1'b0;
    logic       reset, launch;
    logic [9:0] ball_x, ball_y, platx;
    logic       frame_tick, brick_ack, brick_hit;
    logic       move_en, x_du, y_du, pos_resetn, brick_req, brick_clr, plat_col, game_over;
    logic [9:0] brick_qx, brick_qy;
    logic [1:0] lives;

    logic       frame_tick2, brick_ack2, brick_hit2;
    logic       move_en2, x_du2, y_du2, pos_resetn2, brick_req2, brick_clr2, plat_col2, game_over2;
    logic [9:0] brick_qx2, brick_qy2;
    logic [1:0] lives2;

    always #5 clk = ~clk;

    ball_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
        .ball_x(ball_x), .ball_y(ball_y), .platx(platx),
        .brick_ack(brick_ack), .brick_hit(brick_hit),
        .move_en(move_en), .x_du(x_du), .y_du(y_du), .pos_resetn(pos_resetn),
        .brick_req(brick_req), .brick_qx(brick_qx), .brick_qy(brick_qy),
        .brick_clr(brick_clr), .plat_col(plat_col), .lives(lives), .game_over(game_over)
    );

    ball_ctrl #(.STEPS(2)) dut2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick2), .launch(launch),
        .ball_x(ball_x), .ball_y(ball_y), .platx(platx),
        .brick_ack(brick_ack2), .brick_hit(brick_hit2),
        .move_en(move_en2), .x_du(x_du2), .y_du(y_du2), .pos_resetn(pos_resetn2),
        .brick_req(brick_req2), .brick_qx(brick_qx2), .brick_qy(brick_qy2),
        .brick_clr(brick_clr2), .plat_col(plat_col2), .lives(lives2), .game_over(game_over2)
    );

    typedef struct {
        logic [9:0]  bx, by, px;
        int unsigned dly;
        logic        hit;
        int unsigned e_req;
        logic [9:0]  e_qx, e_qy;
        int unsigned e_plat, e_move, e_clr, e_srv;
        logic        e_x, e_y;
        logic [1:0]  e_lives;
        logic        e_go;
    } vec_t;

    vec_t        vt[15];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic vec_t mkv(input int unsigned bx, by, px, dly, hit, e_req, e_qx, e_qy,
                                 e_plat, e_move, e_clr, e_srv, e_x, e_y, e_lives, e_go);
        vec_t v;
        v.bx = 10'(bx); v.by = 10'(by); v.px = 10'(px);
        v.dly = dly; v.hit = hit[0]; v.e_req = e_req;
        v.e_qx = 10'(e_qx); v.e_qy = 10'(e_qy);
        v.e_plat = e_plat; v.e_move = e_move; v.e_clr = e_clr; v.e_srv = e_srv;
        v.e_x = e_x[0]; v.e_y = e_y[0]; v.e_lives = 2'(e_lives); v.e_go = e_go[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // one frame tick on dut, 30-cycle observation window, brick lookup answered after v.dly req cycles
    task automatic run_vec(input vec_t v, input int idx);
        int unsigned n_req, n_plat, n_move, n_clr, n_srv;
        logic [9:0] qx, qy;
        n_req = 0; n_plat = 0; n_move = 0; n_clr = 0; n_srv = 0; qx = '0; qy = '0;
        ball_x = v.bx; ball_y = v.by; platx = v.px;
        frame_tick = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            brick_ack  = 1'b0;
            if (move_en)     n_move++;
            if (plat_col)    n_plat++;
            if (!pos_resetn) n_srv++;
            if (brick_req) begin
                n_req++;
                qx = brick_qx;
                qy = brick_qy;
                if (n_req == v.dly) begin
                    brick_ack = 1'b1;
                    brick_hit = v.hit;
                end
            end
            #1;
            if (brick_clr) n_clr++;
        end
        chk($sformatf("v%0d.req_cycles", idx), n_req, v.e_req);
        if (v.e_req != 0) begin
            chk($sformatf("v%0d.brick_qx", idx), qx, v.e_qx);
            chk($sformatf("v%0d.brick_qy", idx), qy, v.e_qy);
        end
        chk($sformatf("v%0d.plat_col", idx), n_plat, v.e_plat);
        chk($sformatf("v%0d.move_en", idx), n_move, v.e_move);
        chk($sformatf("v%0d.brick_clr", idx), n_clr, v.e_clr);
        chk($sformatf("v%0d.serve", idx), n_srv, v.e_srv);
        chk($sformatf("v%0d.x_du", idx), x_du, v.e_x);
        chk($sformatf("v%0d.y_du", idx), y_du, v.e_y);
        chk($sformatf("v%0d.lives", idx), lives, v.e_lives);
        chk($sformatf("v%0d.game_over", idx), game_over, v.e_go);
    endtask

    initial begin
        int unsigned n_low, n_move2;
        logic        seen;

        //         bx   by   px dly hit req  qx   qy pl mv cl sv x  y  lv go
        vt[0]  = mkv( 80,  60,  0, 2, 0,  2,  81,  59, 0, 1, 0, 0, 1, 0, 3, 0);
        vt[1]  = mkv(158,  60,  0, 2, 0,  2, 157,  59, 0, 1, 0, 0, 0, 0, 3, 0);
        vt[2]  = mkv( 40,  30,  0, 5, 1,  5,  39,  29, 0, 1, 1, 0, 0, 1, 3, 0);
        vt[3]  = mkv( 75, 108, 70, 2, 0,  0,   0,   0, 1, 1, 0, 0, 0, 0, 3, 0);
        vt[4]  = mkv(  0,   0,  0, 2, 0,  0,   0,   0, 0, 1, 0, 0, 1, 1, 3, 0);
        vt[5]  = mkv( 68, 108, 70, 2, 0,  2,  69, 109, 0, 1, 0, 0, 1, 1, 3, 0);
        vt[6]  = mkv( 69, 108, 70, 2, 0,  0,   0,   0, 1, 1, 0, 0, 1, 0, 3, 0);
        vt[7]  = mkv(157,  50,  0, 2, 0,  2, 158,  49, 0, 1, 0, 0, 1, 0, 3, 0);
        vt[8]  = mkv( 10,   0,  0, 2, 0,  0,   0,   0, 0, 1, 0, 0, 1, 1, 3, 0);
        vt[9]  = mkv( 10, 118,  0, 2, 0,  0,   0,   0, 0, 0, 0, 1, 1, 0, 2, 0);
        vt[10] = mkv( 10,   0,  0, 2, 0,  0,   0,   0, 0, 1, 0, 0, 1, 1, 2, 0);
        vt[11] = mkv( 10, 118,  0, 2, 0,  0,   0,   0, 0, 0, 0, 1, 1, 0, 1, 0);
        vt[12] = mkv( 10,   0,  0, 2, 0,  0,   0,   0, 0, 1, 0, 0, 1, 1, 1, 0);
        vt[13] = mkv( 10, 118,  0, 2, 0,  0,   0,   0, 0, 0, 0, 0, 1, 1, 0, 1);
        vt[14] = mkv( 80,  60,  0, 2, 0,  0,   0,   0, 0, 0, 0, 0, 1, 1, 0, 1);

        reset = 1'b1; launch = 1'b0; frame_tick = 1'b0; brick_ack = 1'b0; brick_hit = 1'b0;
        frame_tick2 = 1'b0; brick_ack2 = 1'b0; brick_hit2 = 1'b0;
        ball_x = 10'd80; ball_y = 10'd60; platx = '0;
        repeat (3) @(negedge clk);
        chk("rst.pos_resetn", pos_resetn, 0);
        chk("rst.x_du", x_du, 1);
        chk("rst.y_du", y_du, 0);
        chk("rst.lives", lives, 3);
        chk("rst.game_over", game_over, 0);
        chk("rst.move_en", move_en, 0);
        chk("rst.brick_req", brick_req, 0);

        // serve lasts one cycle after reset release
        launch = 1'b1;
        reset  = 1'b0;
        n_low  = 0;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (!pos_resetn) n_low++;
            @(negedge clk);
        end
        chk("serve.low_cycles", n_low, 1);
        chk("serve.no_move", move_en, 0);

        for (int i = 0; i < 15; i++)
            run_vec(vt[i], i);

        // STEPS=2 instance: stall on the first lookup while two extra ticks arrive
        ball_x = 10'd80; ball_y = 10'd60; platx = '0;
        frame_tick2 = 1'b1;
        n_move2 = 0;
        seen = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            frame_tick2 = (c == 3 || c == 6);
            brick_ack2  = (c > 10) ? brick_req2 : 1'b0;
            if (c == 10) seen = brick_req2;
            if (move_en2) n_move2++;
        end
        brick_ack2 = 1'b0;
        chk("stall.req_held", seen, 1);
        chk("stall.move_en_total", n_move2, 4);
        chk("stall.brick_qx", brick_qx2, 81);
        chk("stall.brick_qy", brick_qy2, 59);
        chk("stall.lives", lives2, 3);
        chk("stall.plat_col", plat_col2, 0);
        chk("stall.brick_clr", brick_clr2, 0);

        // ack in WAIT must not flip direction
        brick_ack2 = 1'b1; brick_hit2 = 1'b1;
        @(negedge clk);
        brick_ack2 = 1'b0; brick_hit2 = 1'b0;
        @(negedge clk);
        chk("stray_ack.y_du", y_du2, 0);

        // reset while a lookup is outstanding
        frame_tick2 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            frame_tick2 = 1'b0;
            seen = brick_req2;
        end
        chk("rstreq.req_seen", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstreq.brick_req", brick_req2, 0);
        chk("rstreq.pos_resetn", pos_resetn2, 0);
        chk("rstreq.game_over2", game_over2, 0);
        chk("rstreq.x_du2", x_du2, 1);
        chk("rstreq.dut_game_over", game_over, 0);
        chk("rstreq.dut_lives", lives, 3);
        reset = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
